rv_prefetch_unit: RTL

Parametrised instruction-prefetch unit for the rv32e core family. It replaces the core's single-shot fetch state with a decoupled fetcher: it issues 4-byte reads to the external SPI memory controller and buffers {pc, instruction} pairs in a DEPTH-entry FIFO. The decode/execute sequencer pops entries through a valid/ready handshake. Branches and jumps redirect the fetch PC and flush the buffer; a redirect that lands while an SPI transfer is in flight discards that transfer's data.

---
 rtl/rv_prefetch_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/rv_prefetch_unit.sv
// rv_prefetch_unit: decoupled instruction fetcher for the rv32e core family.
// Issues 4-byte reads to the SPI memory controller, buffers {pc, instruction}
// pairs in a DEPTH-entry FIFO and hands them to the sequencer over valid/ready.
// A redirect reloads the fetch PC, flushes the buffer and discards the data of
// any transfer still in flight.
module rv_prefetch_unit #(
  parameter int                ADDR_W   = 25,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_start_request,
  input  logic              mem_request_done,
  input  logic [31:0]       mem_fetched_value,
  output logic [ADDR_W-1:0] mem_target_address,
  output logic [2:0]        mem_num_bytes,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] redirect_aligned;

  logic [31:0]       data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic push;
  logic pop;

  // Pointer advance that wraps at DEPTH (DEPTH need not fill the pointer range).
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Instructions are always word aligned, so the low address bits of a
  // redirect target are dropped here rather than trusted.
  assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

  // A redirect outranks both ends of the FIFO: the landing data and any
  // same-cycle pop of now-stale contents are both suppressed.
  assign push = (state == REQ) && mem_request_done && !redirect_valid;
  assign pop  = instr_valid && instr_ready && !redirect_valid;

  assign instr_valid   = (count != '0);
  assign instr_data    = data_mem[rd_ptr];
  assign instr_pc      = pc_mem[rd_ptr];
  assign busy          = (state != IDLE);
  assign mem_num_bytes = 3'd4;

  // Fetch FSM: owns the fetch PC and the request/address lines to the controller.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      mem_start_request <= 1'b0;
      fetch_pc          <= RESET_PC;
    end else begin
      if (redirect_valid) begin
        fetch_pc <= redirect_aligned;
      end
      case (state)
        IDLE: begin
          if (!halt && !redirect_valid && (count < DEPTH_C)) begin
            state              <= REQ;
            mem_start_request  <= 1'b1;
            mem_target_address <= fetch_pc;
          end
        end
        REQ: begin
          if (redirect_valid) begin
            // The controller cannot be aborted; finish the transfer and drop it.
            if (mem_request_done) begin
              mem_start_request <= 1'b0;
              state             <= RELEASE;
            end else begin
              state <= DRAIN;
            end
          end else if (mem_request_done) begin
            fetch_pc          <= fetch_pc + ADDR_W'(4);
            mem_start_request <= 1'b0;
            state             <= RELEASE;
          end
        end
        DRAIN: begin
          if (mem_request_done) begin
            mem_start_request <= 1'b0;
            state             <= RELEASE;
          end
        end
        RELEASE: begin
          // Guarantees start is seen low before the next transfer begins.
          if (!mem_request_done) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // FIFO occupancy and pointers; a redirect empties the buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= mem_fetched_value;
      pc_mem[wr_ptr]   <= fetch_pc;
    end
  end

endmodule
